// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU: IDLE/FETCH/EXEC/MEM/OUT/HALT FSM on one req/ack memory port.
// Define ACC_CPU_ILLEGAL_TRAP_EN to halt with a sticky illegal_op on undefined opcodes.
module acc_cpu_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  localparam int INSTR_W = 8 + DATA_W
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_ack,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  input  logic               out_ready,
  output logic               halted,
  output logic               illegal_op,
  output logic [ADDR_W-1:0]  dbg_pc,
  output logic [DATA_W-1:0]  dbg_acc,
  output logic [INSTR_W-1:0] dbg_ir,
  output logic [1:0]         dbg_flags
);
  localparam logic [7:0] OP_NOP  = 8'h00, OP_LDI = 8'h10, OP_LD  = 8'h11, OP_ST  = 8'h20;
  localparam logic [7:0] OP_ADDI = 8'h30, OP_ADD = 8'h31, OP_SUBI = 8'h40, OP_SUB = 8'h41;
  localparam logic [7:0] OP_ANDI = 8'h50, OP_AND = 8'h51, OP_INC = 8'h60, OP_JMP = 8'h70;
  localparam logic [7:0] OP_JZ   = 8'h71, OP_JC  = 8'h72, OP_OUT = 8'h80, OP_HALT = 8'hF0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_OUT = 3'd4, S_HALT = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic                z_q, z_d, c_q, c_d;
  logic [DATA_W:0]     alu_s;
  logic [7:0]          opcode_s;
  logic [DATA_W-1:0]   opnd_s;
  logic [ADDR_W-1:0]   addr_s;
  logic                is_store_s;

  assign opcode_s   = ir_q[INSTR_W-1:INSTR_W-8];
  assign opnd_s     = ir_q[DATA_W-1:0];
  assign addr_s     = opnd_s[ADDR_W-1:0];
  assign is_store_s = (opcode_s == OP_ST);

  // kind is opcode[7:4]; result is {carry/borrow, value}. Wider subtract leaves borrow in the top bit.
  function automatic logic [DATA_W:0] alu_f(input logic [3:0] kind, input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b, input logic c_in);
    case (kind)
      4'h1:    alu_f = {c_in, b};
      4'h3:    alu_f = {1'b0, a} + {1'b0, b};
      4'h4:    alu_f = {1'b0, a} - {1'b0, b};
      4'h5:    alu_f = {1'b0, a & b};
      4'h6:    alu_f = {1'b0, a} + {{DATA_W{1'b0}}, 1'b1};
      default: alu_f = {c_in, a};
    endcase
  endfunction

  function automatic logic legal_f(input logic [7:0] op);
    case (op)
      OP_NOP, OP_LDI, OP_LD, OP_ST, OP_ADDI, OP_ADD, OP_SUBI, OP_SUB, OP_ANDI, OP_AND,
      OP_INC, OP_JMP, OP_JZ, OP_JC, OP_OUT, OP_HALT: legal_f = 1'b1;
      default: legal_f = 1'b0;
    endcase
  endfunction

`ifdef ACC_CPU_ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
  logic illegal_q, illegal_d;

  always_comb begin
    if (state_q == S_EXEC && !legal_f(opcode_s)) illegal_d = 1'b1;
    else illegal_d = illegal_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) illegal_q <= 1'b0;
    else illegal_q <= illegal_d;
  end

  assign illegal_op = illegal_q;
`else
  localparam logic TRAP_EN = 1'b0;
  assign illegal_op = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      acc_q   <= {DATA_W{1'b0}};
      ir_q    <= {INSTR_W{1'b0}};
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (mem_ack) state_d = S_EXEC; else state_d = S_FETCH;
      S_EXEC: begin
        case (opcode_s)
          OP_LD, OP_ADD, OP_SUB, OP_AND, OP_ST: state_d = S_MEM;
          OP_OUT:  state_d = S_OUT;
          OP_HALT: state_d = S_HALT;
          default: if (TRAP_EN && !legal_f(opcode_s)) state_d = S_HALT; else state_d = S_FETCH;
        endcase
      end
      S_MEM:   if (mem_ack) state_d = S_FETCH; else state_d = S_MEM;
      S_OUT:   if (out_ready) state_d = S_FETCH; else state_d = S_OUT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d  = pc_q;
    acc_d = acc_q;
    ir_d  = ir_q;
    z_d   = z_q;
    c_d   = c_q;
    alu_s = {(DATA_W+1){1'b0}};
    case (state_q)
      S_FETCH: begin
        if (mem_ack) begin
          ir_d = mem_rdata;
          pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
          ir_d = ir_q;
        end
      end
      S_EXEC: begin
        case (opcode_s)
          OP_LDI, OP_ADDI, OP_SUBI, OP_ANDI, OP_INC: begin
            alu_s = alu_f(opcode_s[7:4], acc_q, opnd_s, c_q);
            c_d   = alu_s[DATA_W];
            acc_d = alu_s[DATA_W-1:0];
            z_d   = (alu_s[DATA_W-1:0] == {DATA_W{1'b0}});
          end
          OP_JMP:  pc_d = addr_s;
          OP_JZ:   if (z_q) pc_d = addr_s; else pc_d = pc_q;
          OP_JC:   if (c_q) pc_d = addr_s; else pc_d = pc_q;
          default: pc_d = pc_q;
        endcase
      end
      S_MEM: begin
        if (mem_ack && !is_store_s) begin
          alu_s = alu_f(opcode_s[7:4], acc_q, mem_rdata[DATA_W-1:0], c_q);
          c_d   = alu_s[DATA_W];
          acc_d = alu_s[DATA_W-1:0];
          z_d   = (alu_s[DATA_W-1:0] == {DATA_W{1'b0}});
        end else begin
          acc_d = acc_q;
        end
      end
      default: pc_d = pc_q;
    endcase
  end

  // Outputs depend on registered state only, so they are stable for a whole cycle.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {INSTR_W{1'b0}};
    out_valid = 1'b0;
    out_data  = {DATA_W{1'b0}};
    halted    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_addr = addr_s;
        if (is_store_s) begin
          mem_we    = 1'b1;
          mem_wdata = {8'h00, acc_q};
        end else begin
          mem_we    = 1'b0;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        out_data  = acc_q;
      end
      S_HALT:  halted = 1'b1;
      default: mem_req = 1'b0;
    endcase
  end

  assign dbg_pc    = pc_q;
  assign dbg_acc   = acc_q;
  assign dbg_ir    = ir_q;
  assign dbg_flags = {c_q, z_q};
endmodule

// File: tb/tb_acc_cpu_core.sv
// Bench for acc_cpu_core: wait-state memory and stalling sink models, checked against an ISA-level interpreter.
module tb_acc_cpu_core;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata = 16'h0000;
  logic        out_valid, out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        halted, illegal_op;
  logic [7:0]  dbg_pc, dbg_acc;
  logic [15:0] dbg_ir;
  logic [1:0]  dbg_flags;

  int checks = 0;
  int errors = 0;
  logic [15:0] mem [256];
  logic [15:0] m_mem [256];
  int mem_waits = 0;
  bit rand_w = 1'b0;
  int ready_delay = 0;
  logic [8:0]  trace_q [$];
  logic [23:0] wr_q [$];
  logic [7:0]  out_q [$];
  logic [8:0]  exp_trace [$];
  logic [23:0] exp_wr [$];
  logic [7:0]  exp_out [$];
  int exp_cycles, exp_pc, exp_acc, exp_flags, exp_illegal;
  logic [15:0] exp_ir;
  logic [7:0] op_tab [15] = '{8'h00, 8'h10, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h71,
                              8'h72, 8'h11, 8'h31, 8'h41, 8'h51, 8'h20, 8'h80};

  acc_cpu_core dut (
    .clk(clk), .reset_n(reset_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .halted(halted), .illegal_op(illegal_op),
    .dbg_pc(dbg_pc), .dbg_acc(dbg_acc), .dbg_ir(dbg_ir), .dbg_flags(dbg_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory wrapper: mem_waits (or random 0..3) wait cycles per transaction, request held stable.
  initial begin
    int wcnt, cur_w;
    logic [7:0] lat_addr;
    logic lat_we;
    logic [15:0] lat_wdata;
    wcnt = 0; cur_w = 0; lat_addr = 8'h00; lat_we = 1'b0; lat_wdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (mem_req !== 1'b1) begin
        mem_ack = 1'b0;
        wcnt = 0;
      end else begin
        if (wcnt == 0) begin
          cur_w = rand_w ? int'($urandom_range(0, 3)) : mem_waits;
          lat_addr = mem_addr; lat_we = mem_we; lat_wdata = mem_wdata;
        end else begin
          chk("req_addr_stable", 32'(mem_addr), 32'(lat_addr));
          chk("req_we_stable", 32'(mem_we), 32'(lat_we));
          chk("req_wdata_stable", 32'(mem_wdata), 32'(lat_wdata));
        end
        if (wcnt == cur_w) begin
          mem_ack = 1'b1;
          mem_rdata = mem[mem_addr];
          trace_q.push_back({mem_we, mem_addr});
          if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            wr_q.push_back({mem_addr, mem_wdata});
          end
          wcnt = 0;
        end else begin
          mem_ack = 1'b0;
          mem_rdata = 16'($urandom);
          wcnt++;
        end
      end
    end
  end

  // Output sink: holds out_ready low for ready_delay cycles of each offer, logs each transfer.
  initial begin
    logic prev_valid, prev_ready;
    logic [7:0] prev_data;
    int hold_cnt;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_data = 8'h00; hold_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset_n && prev_valid && prev_ready) out_q.push_back(prev_data);
      if (reset_n && prev_valid && !prev_ready) begin
        chk("out_valid_held", 32'(out_valid), 32'd1);
        chk("out_data_held", 32'(out_data), 32'(prev_data));
      end
      if (out_valid === 1'b1) begin
        if (hold_cnt < ready_delay) begin
          out_ready = 1'b0;
          hold_cnt++;
        end else begin
          out_ready = 1'b1;
        end
      end else begin
        out_ready = 1'b0;
        hold_cnt = 0;
      end
      prev_valid = (out_valid === 1'b1); prev_ready = out_ready; prev_data = out_data;
    end
  end

  // Instruction-level interpreter: architectural results, bus trace and cycle cost per instruction.
  task automatic model_run();
    int pc, acc, c, z, op, opnd, v, s;
    bit done;
    pc = 0; acc = 0; c = 0; z = 0; done = 1'b0;
    exp_cycles = 1; exp_illegal = 0; exp_ir = 16'h0000;
    exp_trace.delete(); exp_wr.delete(); exp_out.delete();
    for (int steps = 0; steps < 500 && !done; steps++) begin
      exp_ir = m_mem[pc];
      op = int'(m_mem[pc][15:8]);
      opnd = int'(m_mem[pc][7:0]);
      exp_trace.push_back({1'b0, 8'(pc)});
      pc = (pc + 1) % 256;
      exp_cycles += 2 + mem_waits;
      v = opnd;
      if (op inside {'h11, 'h31, 'h41, 'h51}) begin
        v = int'(m_mem[opnd][7:0]);
        exp_trace.push_back({1'b0, 8'(opnd)});
        exp_cycles += 1 + mem_waits;
        op = op - 1;
      end
      case (op)
        'h00: ;
        'h10: begin acc = v; z = int'(acc == 0); end
        'h30: begin s = acc + v; c = int'(s > 255); acc = s % 256; z = int'(acc == 0); end
        'h40: begin c = int'(acc < v); acc = (acc - v + 256) % 256; z = int'(acc == 0); end
        'h50: begin acc = acc & v; c = 0; z = int'(acc == 0); end
        'h60: begin s = acc + 1; c = int'(s > 255); acc = s % 256; z = int'(acc == 0); end
        'h70: pc = opnd;
        'h71: if (z != 0) pc = opnd;
        'h72: if (c != 0) pc = opnd;
        'h20: begin
          m_mem[opnd] = {8'h00, 8'(acc)};
          exp_wr.push_back({8'(opnd), 8'h00, 8'(acc)});
          exp_trace.push_back({1'b1, 8'(opnd)});
          exp_cycles += 1 + mem_waits;
        end
        'h80: begin exp_out.push_back(8'(acc)); exp_cycles += 1 + ready_delay; end
        'hF0: done = 1'b1;
        default: begin
`ifdef ACC_CPU_ILLEGAL_TRAP_EN
          exp_illegal = 1; done = 1'b1;
`endif
        end
      endcase
    end
    exp_pc = pc; exp_acc = acc; exp_flags = c * 2 + z;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    trace_q.delete(); wr_q.delete(); out_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_illegal_op"}, 32'(illegal_op), 32'd0);
    chk({tag, "_pc"}, 32'(dbg_pc), 32'd0);
    chk({tag, "_acc"}, 32'(dbg_acc), 32'd0);
    chk({tag, "_ir"}, 32'(dbg_ir), 32'd0);
    chk({tag, "_flags"}, 32'(dbg_flags), 32'd0);
  endtask

  task automatic run_prog(input string tag, input bit check_cycles);
    int cyc;
    bit got;
    m_mem = mem;
    model_run();
    do_reset();
    reset_n = 1'b1;
    cyc = 0; got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (halted === 1'b1) got = 1'b1;
    end
    chk({tag, "_halt_reached"}, 32'(got), 32'd1);
    chk({tag, "_acc"}, 32'(dbg_acc), 32'(exp_acc));
    chk({tag, "_flags"}, 32'(dbg_flags), 32'(exp_flags));
    chk({tag, "_pc"}, 32'(dbg_pc), 32'(exp_pc));
    chk({tag, "_ir"}, 32'(dbg_ir), 32'(exp_ir));
    chk({tag, "_illegal"}, 32'(illegal_op), 32'(exp_illegal));
    if (check_cycles) chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cycles));
    chk({tag, "_out_count"}, 32'(out_q.size()), 32'(exp_out.size()));
    for (int i = 0; i < out_q.size() && i < exp_out.size(); i++)
      chk({tag, "_out_data"}, 32'(out_q[i]), 32'(exp_out[i]));
    chk({tag, "_wr_count"}, 32'(wr_q.size()), 32'(exp_wr.size()));
    for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++)
      chk({tag, "_wr"}, 32'(wr_q[i]), 32'(exp_wr[i]));
    chk({tag, "_trace_len"}, 32'(trace_q.size()), 32'(exp_trace.size()));
    for (int i = 0; i < trace_q.size() && i < exp_trace.size(); i++)
      chk({tag, "_trace"}, 32'(trace_q[i]), 32'(exp_trace[i]));
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 256; a++) mem[a] = 16'hF000;
  endtask

  task automatic gen_random();
    int n, op, opnd;
    for (int a = 0; a < 128; a++) mem[a] = 16'hF000;
    for (int a = 128; a < 256; a++) mem[a] = 16'($urandom);
    n = int'($urandom_range(4, 40));
    for (int i = 0; i < n; i++) begin
      op = int'(op_tab[$urandom_range(0, 14)]);
      if (op inside {'h70, 'h71, 'h72}) opnd = int'($urandom_range(i + 1, n));
      else if (op inside {'h11, 'h31, 'h41, 'h51, 'h20}) opnd = int'($urandom_range(128, 255));
      else opnd = int'($urandom_range(0, 255));
      mem[i] = {8'(op), 8'(opnd)};
    end
  endtask

  initial begin
    bit found;
    clear_mem();
    do_reset();
    check_reset_outputs("reset");

    // LDI 05; ADDI 03; OUT; HALT
    mem[0] = 16'h1005; mem[1] = 16'h3003; mem[2] = 16'h8000; mem[3] = 16'hF000;
    mem_waits = 0; rand_w = 1'b0; ready_delay = 0;
    run_prog("basic", 1'b1);
    chk("basic_out_is_08", (out_q.size() == 1) ? 32'(out_q[0]) : 32'hFFFF, 32'h08);

    ready_delay = 4;
    run_prog("stall_out", 1'b1);
    ready_delay = 0;

    // LDI FF; INC; JZ 06; NOPs; HALT at 06
    clear_mem();
    mem[0] = 16'h10FF; mem[1] = 16'h6000; mem[2] = 16'h7106;
    mem[3] = 16'h0000; mem[4] = 16'h0000; mem[5] = 16'h0000; mem[6] = 16'hF000;
    run_prog("jz", 1'b1);
    chk("jz_flags_cz", 32'(dbg_flags), 32'd3);
    chk("jz_next_fetch", (trace_q.size() > 3) ? 32'(trace_q[3]) : 32'hFFFF, 32'h006);

    // LDI 5A; ST 20; LD 21; ADD 20; HALT with zero and three wait states
    clear_mem();
    mem[0] = 16'h105A; mem[1] = 16'h2020; mem[2] = 16'h1121; mem[3] = 16'h3120; mem[4] = 16'hF000;
    mem[8'h21] = 16'h0033;
    run_prog("mem0", 1'b1);
    chk("mem0_acc_8d", 32'(dbg_acc), 32'h8D);
    chk("mem0_store", (wr_q.size() > 0) ? 32'(wr_q[0]) : 32'hFFFFFF, 32'h20005A);
    mem_waits = 3;
    run_prog("mem3", 1'b1);
    chk("mem3_acc_8d", 32'(dbg_acc), 32'h8D);
    mem_waits = 0;

    // Wrap boundaries: FF+01, 00-01, ANDI clears C
    clear_mem();
    mem[0] = 16'h10FF; mem[1] = 16'h3001; mem[2] = 16'h8000; mem[3] = 16'h4001;
    mem[4] = 16'h8000; mem[5] = 16'h500F; mem[6] = 16'h8000; mem[7] = 16'hF000;
    run_prog("wrap", 1'b1);
    chk("wrap_add_out", (out_q.size() > 0) ? 32'(out_q[0]) : 32'hFFFF, 32'h00);
    chk("wrap_sub_out", (out_q.size() > 1) ? 32'(out_q[1]) : 32'hFFFF, 32'hFF);

    // Undefined opcode EE
    clear_mem();
    mem[0] = 16'hEE00; mem[1] = 16'hF000;
    run_prog("illegal", 1'b1);

    // Jump to itself
    clear_mem();
    mem[0] = 16'h7000;
    do_reset();
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("loop_fetch_count", 32'(trace_q.size() >= 4), 32'd1);
    foreach (trace_q[i]) chk("loop_fetch_addr", 32'(trace_q[i]), 32'h000);
    chk("loop_not_halted", 32'(halted), 32'd0);

    // Reset during a MEM wait
    clear_mem();
    mem[0] = 16'h1190; mem[8'h90] = 16'h1234;
    mem_waits = 3;
    do_reset();
    reset_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (mem_req === 1'b1 && mem_addr === 8'h90) found = 1'b1;
    end
    chk("mem_wait_seen", 32'(found), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_mem");
    mem_waits = 0;

    // Reset during OUT
    clear_mem();
    mem[0] = 16'h1077; mem[1] = 16'h8000;
    ready_delay = 10;
    do_reset();
    reset_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) found = 1'b1;
    end
    chk("out_seen", 32'(found), 32'd1);
    chk("out_pending_data", 32'(out_data), 32'h77);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_out");
    chk("rst_out_no_xfer", 32'(out_q.size()), 32'd0);

    // Random forward-flowing programs, random wait states and sink stalls
    rand_w = 1'b1;
    for (int p = 0; p < 20; p++) begin
      ready_delay = int'($urandom_range(0, 3));
      gen_random();
      run_prog("rand", 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
